serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Sequencer that performs wide (WIDTH*CHUNKS-bit) add/subtract by time-multiplexing one narrow ripple_carry_adder #(WIDTH) instance over CHUNKS cycles, LSB chunk first.
- Saves area versus a full-width ripple adder.
- Sits between the RSA modular-arithmetic control and its operand registers.
- Inter-chunk carry is held in a flop.

Parameters:
- WIDTH, 4: adder slice width in bits; passed to the internal ripple_carry_adder.
- CHUNKS, 8: number of slices per operation. Operand width N = WIDTH*CHUNKS. CHUNKS >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  N  operand A; sampled with start.
- b  input  N  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result/carry_out become valid.
- result  output  N  sum/difference modulo 2^N; held until next accepted start.
- carry_out  output  1  final carry. For sub: 1 = no borrow (a >= b), 0 = borrow.

Behaviour:
- Reset (async assert, sync-safe release): state = IDLE.
  - busy = 0, done = 0, result = 0, carry_out = 0.
  - Internal operand shift registers, carry flop and chunk counter all cleared.
- States: IDLE, RUN, DONE. Encoding is free; no illegal-state lockup (default -> IDLE).
- IDLE: on rising edge with start = 1:
  - latch a -> a_sr, b -> b_sr, sub -> sub_q;
  - carry flop <= sub; counter <= 0; next state RUN.
  - With start = 0: stay in IDLE, outputs hold.
- RUN, each cycle:
  - Adder inputs: a_sr[WIDTH-1:0], b_sr[WIDTH-1:0] XOR {WIDTH{sub_q}}, ci = carry flop.
  - On the edge:
    - result shifts right by WIDTH with the adder sum inserted at result[N-1:N-WIDTH];
    - a_sr and b_sr shift right by WIDTH (zero fill);
    - carry flop <= adder co;
    - counter increments.
  - After the edge where counter == CHUNKS-1 is processed: carry_out <= adder co, next state DONE.
- result is a working register. Its contents are only meaningful when done = 1 or afterwards in IDLE.
- DONE: lasts exactly one cycle.
  - done = 1, busy = 0.
  - Next state IDLE unconditionally.
- Latency: start sampled at edge E0. RUN occupies edges E1..E_CHUNKS. done is high in the cycle after edge E_CHUNKS. For defaults, done is seen 9 cycles after the start edge.
- Throughput: next start is accepted in the IDLE cycle following DONE, giving one operation per CHUNKS+2 cycles.
- start while busy or in DONE: ignored; no effect on the in-flight operation.
- a/b/sub changing during RUN: no effect, since inputs are captured at start.
- Reset mid-RUN: immediate return to IDLE with all outputs cleared; no done pulse.
- Arithmetic is modulo 2^N; no overflow flag.
- Subtract uses two's complement: invert B and set ci = 1 on the first chunk.

Test Plan:
- Add with full carry ripple (defaults): a=0xFFFFFFFF, b=0x00000001, sub=0 -> done pulse 9 cycles after start; result=0x00000000, carry_out=1; busy high for exactly 8 cycles.
- Plain add: a=0x12345678, b=0x11111111, sub=0 -> result=0x23456789, carry_out=0.
- Subtract with borrow: a=5, b=7, sub=1 -> result=0xFFFFFFFE, carry_out=0. Subtract without borrow: a=7, b=5, sub=1 -> result=0x00000002, carry_out=1.
- Start ignored while busy: start a=1, b=1; hold start high throughout with a=0xAAAAAAAA -> exactly one done, result=0x00000002. A second op is accepted in the IDLE cycle right after done.
- Reset mid-operation: assert rst at cycle 4 of RUN -> same cycle busy=0, done=0, result=0, carry_out=0. No done pulse follows. A fresh a=3, b=4 then yields result=7.
- Parameter sweep: WIDTH=1, CHUNKS=16 and WIDTH=8, CHUNKS=2 with random operands checked against a reference add/sub model. done latency must be CHUNKS+1 cycles in every case.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Wide add/subtract sequencer: one WIDTH-bit ripple adder reused over CHUNKS cycles,
// least-significant chunk first, with the inter-chunk carry held in a flop.

module ripple_carry_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH:0] carry;

  assign carry[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign s[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign co = carry[WIDTH];

endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CHUNKS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sub,
  input  logic [WIDTH*CHUNKS-1:0]   a,
  input  logic [WIDTH*CHUNKS-1:0]   b,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH*CHUNKS-1:0]   result,
  output logic                      carry_out
);

  localparam int unsigned N    = WIDTH * CHUNKS;
  localparam int unsigned CntW = $clog2(CHUNKS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      a_sr_q, a_sr_d;
  logic [N-1:0]      b_sr_q, b_sr_d;
  logic [N-1:0]      result_q, result_d;
  logic              sub_q, sub_d;
  logic              carry_q, carry_d;
  logic              carry_out_q, carry_out_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]  add_b;
  logic [WIDTH-1:0]  add_s;
  logic              add_co;
  logic              last_chunk;

  // Subtraction feeds ~b; the +1 comes from the carry flop being preset to sub.
  assign add_b      = b_sr_q[WIDTH-1:0] ^ {WIDTH{sub_q}};
  assign last_chunk = (cnt_q == CntW'(CHUNKS - 1));

  ripple_carry_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a  (a_sr_q[WIDTH-1:0]),
    .b  (add_b),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      result_q    <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      result_q    <= result_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    result_d    = result_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    cnt_d       = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          sub_d   = sub;
          carry_d = sub;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d = {add_s, result_q[N-1:WIDTH]};
        a_sr_d   = {{WIDTH{1'b0}}, a_sr_q[N-1:WIDTH]};
        b_sr_d   = {{WIDTH{1'b0}}, b_sr_q[N-1:WIDTH]};
        carry_d  = add_co;
        cnt_d    = cnt_q + CntW'(1);
        if (last_chunk) begin
          carry_out_d = add_co;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    result    = result_q;
    carry_out = carry_out_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: cycle-level reference model for the default build,
// directed literal vectors, and two alternate slicings checked against plain arithmetic.

module tb_serial_adder_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned C = 8;
  localparam int unsigned N = W * C;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [N-1:0] a     = '0;
  logic [N-1:0] b     = '0;
  logic         busy, done, carry_out;
  logic [N-1:0] result;

  logic         s_start = 1'b0;
  logic         s_sub   = 1'b0;
  logic [15:0]  s_a     = '0;
  logic [15:0]  s_b     = '0;
  logic         w1_busy, w1_done, w1_co;
  logic [15:0]  w1_res;
  logic         w8_busy, w8_done, w8_co;
  logic [15:0]  w8_res;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W), .CHUNKS(C)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out)
  );

  serial_adder_ctrl #(.WIDTH(1), .CHUNKS(16)) u_w1 (
    .clk(clk), .rst(rst), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b),
    .busy(w1_busy), .done(w1_done), .result(w1_res), .carry_out(w1_co)
  );

  serial_adder_ctrl #(.WIDTH(8), .CHUNKS(2)) u_w8 (
    .clk(clk), .rst(rst), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b),
    .busy(w8_busy), .done(w8_done), .result(w8_res), .carry_out(w8_co)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N:0] ref32(input logic [N-1:0] x, input logic [N-1:0] y,
                                       input logic s);
    if (s) return {x >= y, x - y};
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic s);
    if (s) return {x >= y, x - y};
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Model: phase 0 idle, 1..C computing, C+1 the done cycle.
  int           m_phase;
  logic [N-1:0] m_res, p_res;
  logic         m_co, p_co, m_valid;
  int           n_done = 0;
  bit           chk_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_res   <= '0;
      m_co    <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase       <= 1;
        {p_co, p_res} <= ref32(a, b, sub);
        m_valid       <= 1'b0;
      end
    end else if (m_phase == C) begin
      m_phase <= C + 1;
      m_res   <= p_res;
      m_co    <= p_co;
      m_valid <= 1'b1;
    end else if (m_phase == C + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, (m_phase >= 1) && (m_phase <= C));
      chk("done", done, m_phase == C + 1);
      chk("carry_out", carry_out, m_co);
      if (m_valid) chk("result", result, m_res);
      if (done) n_done++;
    end
  end

  // Called just after the start edge; returns edges from start edge to the done cycle.
  task automatic wait_done(output int lat, output int bn);
    bit got;
    lat = 1;
    bn  = 0;
    got = 1'b0;
    while (!got && lat <= 40) begin
      @(negedge clk);
      if (busy) bn++;
      if (done) got = 1'b1;
      else begin
        @(posedge clk);
        #3;
        lat++;
      end
    end
  endtask

  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic ts,
                        input logic [N-1:0] er, input logic ec, input string nm);
    int lat, bn;
    @(posedge clk);
    #3;
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(posedge clk);
    #3;
    start = 1'b0;
    a = ~ta; b = ~tb_; sub = ~ts;
    wait_done(lat, bn);
    chk({nm, "_latency"}, lat, C + 1);
    chk({nm, "_busy_cycles"}, bn, C);
    chk({nm, "_result"}, result, er);
    chk({nm, "_carry"}, carry_out, ec);
  endtask

  task automatic sweep_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts);
    int l1, l8;
    logic [16:0] e;
    e = ref16(ta, tb_, ts);
    @(posedge clk);
    #3;
    s_a = ta; s_b = tb_; s_sub = ts; s_start = 1'b1;
    @(posedge clk);
    #3;
    s_start = 1'b0;
    l1 = -1;
    l8 = -1;
    for (int lat = 1; lat <= 40 && (l1 < 0 || l8 < 0); lat++) begin
      if (lat > 1) begin
        @(posedge clk);
        #3;
      end
      @(negedge clk);
      if (w1_done && l1 < 0) begin
        l1 = lat;
        chk("w1_result", w1_res, e[15:0]);
        chk("w1_carry", w1_co, e[16]);
      end
      if (w8_done && l8 < 0) begin
        l8 = lat;
        chk("w8_result", w8_res, e[15:0]);
        chk("w8_carry", w8_co, e[16]);
      end
    end
    chk("w1_latency", l1, 17);
    chk("w8_latency", l8, 3);
  endtask

  initial begin
    int lat, bn, d0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "wrap_add");
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, "plain_add");
    run_op(32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, "sub_borrow");
    run_op(32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, "sub_no_borrow");

    // start held high through a whole operation; the next one starts right after done
    @(posedge clk);
    #3;
    d0 = n_done;
    a = 32'd1; b = 32'd1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #3;
    a = 32'hAAAA_AAAA;
    wait_done(lat, bn);
    chk("hold_latency", lat, C + 1);
    chk("hold_result", result, 32'h0000_0002);
    @(posedge clk);
    #3;
    @(negedge clk);
    chk("hold_idle_gap", busy, 0);
    @(posedge clk);
    #3;
    start = 1'b0;
    chk("hold_second_accept", busy, 1);
    wait_done(lat, bn);
    chk("second_latency", lat, C + 1);
    chk("second_result", result, 32'hAAAA_AAAB);
    @(posedge clk);
    #3;
    chk("hold_done_count", n_done - d0, 2);

    // reset in the fourth RUN cycle
    @(posedge clk);
    #3;
    a = 32'h0F0F_0F0F; b = 32'd1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #3;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_busy", busy, 1);
    d0  = n_done;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_carry", carry_out, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    chk("no_done_after_rst", n_done - d0, 0);
    run_op(32'd3, 32'd4, 1'b0, 32'd7, 1'b0, "after_rst");

    sweep_op(16'hFFFF, 16'h0001, 1'b0);
    sweep_op(16'h0000, 16'h0001, 1'b1);
    sweep_op(16'h8000, 16'h8000, 1'b0);
    sweep_op(16'h1234, 16'h1234, 1'b1);
    for (int i = 0; i < 6; i++) begin
      sweep_op(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)));
    end

    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
